// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage and its neighbours:
// FSM encoding, datapath widths and the writeback bundle.
package mem_stage_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    MS_IDLE   = 1'b0,
    MS_ACCESS = 1'b1
  } ms_state_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_bundle_t;

endpackage

// File: rtl/mem_stage_timeout_ctr.sv
// Clearable up-counter that flags its terminal count (MAX-1); it parks there
// until cleared so an abandoned access cannot wrap back into range.
module mem_timeout_ctr #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  logic [W-1:0] count;

  assign terminal = (count == W'(MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: turns execute results into writeback bundles, running
// aligned loads/stores over a req/ack handshake with a timeout abort.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rt_value,
  input  logic [REG_W-1:0]  ex_dest_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_dest_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_error,
  output ms_state_t         fsm_state
);

  // Handshake: a transfer from execute happens on a rising edge where
  // ex_valid & ex_ready; ex_ready depends only on the registered state, and
  // execute holds its outputs while it is stalled.

  ms_state_t        state;
  wb_bundle_t       wb_q;
  logic             err_q;
  logic             lat_reg_write;
  logic [REG_W-1:0] lat_dest;
  logic             accept;
  logic             mem_op;
  logic             start_access;
  logic             timed_out;

  assign ex_ready     = (state == MS_IDLE);
  assign accept       = ex_valid & ex_ready;
  assign mem_op       = ex_mem_read | ex_mem_write;
  assign start_access = accept & mem_op & (ex_alu_result[1:0] == 2'b00);

  // Derived from the async-reset state flop so reset drops it immediately.
  assign dmem_req     = (state == MS_ACCESS);

  assign wb_valid     = wb_q.valid;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_dest_reg  = wb_q.dest;
  assign wb_data      = wb_q.data;
  assign mem_error    = err_q;
  assign fsm_state    = state;

  mem_timeout_ctr #(
    .MAX (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_access),
    .en       (state == MS_ACCESS),
    .terminal (timed_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= MS_IDLE;
      wb_q          <= '0;
      err_q         <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      lat_reg_write <= 1'b0;
      lat_dest      <= '0;
    end else begin
      wb_q.valid <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (accept && !mem_op) begin
            wb_q.valid     <= 1'b1;
            wb_q.reg_write <= ex_reg_write;
            wb_q.dest      <= ex_dest_reg;
            wb_q.data      <= ex_alu_result;
          end else if (accept && !start_access) begin
            // Misaligned: report and retire without touching memory.
            wb_q.valid     <= 1'b1;
            wb_q.reg_write <= 1'b0;
            wb_q.dest      <= ex_dest_reg;
            wb_q.data      <= ex_alu_result;
            err_q          <= 1'b1;
          end else if (start_access) begin
            state         <= MS_ACCESS;
            dmem_we       <= ex_mem_write;
            dmem_addr     <= ex_alu_result;
            dmem_wdata    <= ex_rt_value;
            lat_dest      <= ex_dest_reg;
            lat_reg_write <= ex_mem_read & ex_reg_write;
          end
        end
        MS_ACCESS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (dmem_ack) begin
            state          <= MS_IDLE;
            wb_q.valid     <= 1'b1;
            wb_q.reg_write <= lat_reg_write;
            wb_q.dest      <= lat_dest;
            wb_q.data      <= dmem_we ? dmem_addr : dmem_rdata;
          end else if (timed_out) begin
            state          <= MS_IDLE;
            wb_q.valid     <= 1'b1;
            wb_q.reg_write <= 1'b0;
            err_q          <= 1'b1;
          end
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random instructions, an emulated data
// memory, and a writeback scoreboard fed from the instruction rules.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TMO = 16;
  localparam int W   = 72;  // {cycle[31:0], chk_data, err, reg_write, dest[4:0], data[31:0]}

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rt_value;
  logic [4:0]  ex_dest_reg;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_dest_reg;
  logic [31:0] wb_data;
  logic        mem_error;
  ms_state_t   fsm_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  int           vectors = 0;
  int           miscompares = 0;
  int unsigned  cyc = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_rt_value   (ex_rt_value),
    .ex_dest_reg   (ex_dest_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_dest_reg   (wb_dest_reg),
    .wb_data       (wb_data),
    .mem_error     (mem_error),
    .fsm_state     (fsm_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input int unsigned c, input bit chk, input bit err,
                                            input bit rw, input logic [4:0] d, input logic [31:0] data);
    return {c[31:0], chk, err, rw, d, data};
  endfunction

  task automatic check_reset_values();
    check("rst_ex_ready", ex_ready, 1);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_reg_write", wb_reg_write, 0);
    check("rst_wb_dest_reg", wb_dest_reg, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_error", mem_error, 0);
    check("rst_state", fsm_state, MS_IDLE);
  endtask

  // ---------------- driver + memory responder ----------------
  // Called #1 after a rising edge with the stage idle. lat = cycle of ACCESS
  // (1..TMO) in which ack is given; any other value means never.
  task automatic do_op(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] dest,
                       input bit rw, input bit mr, input bit mw, input int lat,
                       input logic [31:0] rdata);
    bit mem;
    bit aligned;
    bit acked;
    mem     = mr | mw;
    aligned = (alu[1:0] == 2'b00);
    acked   = (lat >= 1 && lat <= TMO);
    check("ex_ready_idle", ex_ready, 1);
    ex_valid      = 1'b1;
    ex_alu_result = alu;
    ex_rt_value   = rt;
    ex_dest_reg   = dest;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    dmem_ack      = 1'($urandom_range(0, 1));  // stray ack while idle must be ignored
    if (!mem)
      exp_q.push_back(pack_exp(cyc + 1, 1, 0, rw, dest, alu));
    else if (!aligned)
      exp_q.push_back(pack_exp(cyc + 1, 0, 1, 0, 0, 0));
    else if (acked)
      exp_q.push_back(pack_exp(cyc + 1 + lat, 1, 0, mr & rw, dest, mr ? rdata : alu));
    else
      exp_q.push_back(pack_exp(cyc + 1 + TMO, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    ex_valid      = 1'b0;
    ex_alu_result = $urandom();
    ex_rt_value   = $urandom();
    ex_dest_reg   = 5'($urandom());
    dmem_ack      = 1'b0;
    if (!(mem && aligned)) begin
      check("no_req", dmem_req, 0);
    end else begin
      for (int c = 1; c <= TMO; c++) begin
        @(negedge clk);
        check("req_high", dmem_req, 1);
        check("ex_ready_low", ex_ready, 0);
        check("dmem_addr", dmem_addr, alu);
        check("dmem_we", dmem_we, mw);
        if (mw) check("dmem_wdata", dmem_wdata, rt);
        if (c == lat) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom();
        if (c == lat) break;
      end
      check("req_end", dmem_req, 0);
      check("ex_ready_back", ex_ready, 1);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wb_unexpected at cycle %0d: got wb_valid=1 expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("wb_cycle", 64'(cyc), 64'(e[71:40]));
        check("wb_mem_error", mem_error, e[38]);
        check("wb_reg_write", wb_reg_write, e[37]);
        if (e[39]) begin
          check("wb_dest_reg", wb_dest_reg, e[36:32]);
          check("wb_data", wb_data, e[31:0]);
        end
      end
    end else if (mem_error) begin
      vectors++;
      miscompares++;
      $display("FAIL mem_error_alone at cycle %0d: got mem_error=1 expected wb_valid with it", cyc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    int r;
    int lat;
    logic [31:0] addr;
    reset         = 1'b0;
    ex_valid      = 1'b0;
    ex_alu_result = '0;
    ex_rt_value   = '0;
    ex_dest_reg   = '0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
    #2;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Directed cases.
    do_op(32'h0000_0010, $urandom(), 5'd3, 1, 0, 0, 0, 0);
    do_op(32'h0000_0020, $urandom(), 5'd4, 1, 0, 0, 0, 0);
    do_op(32'h0000_0100, $urandom(), 5'd8, 1, 1, 0, 3, 32'hDEAD_BEEF);
    do_op(32'h0000_0200, 32'h1234_5678, 5'd9, 1, 0, 1, 1, 0);
    do_op(32'h0000_0102, $urandom(), 5'd5, 1, 1, 0, 2, 32'h5555_5555);
    do_op(32'h0000_0300, $urandom(), 5'd6, 1, 1, 0, 0, 0);
    do_op(32'h0000_0304, $urandom(), 5'd7, 1, 1, 0, TMO, 32'hCAFE_F00D);
    do_op(32'h0000_0400, $urandom(), 5'd1, 1, 1, 0, 1, 32'h0BAD_CAFE);
    do_op(32'h0000_0404, $urandom(), 5'd2, 1, 1, 0, 1, 32'h1357_9BDF);

    // Random mix.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom();
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      lat = (r < 7) ? $urandom_range(1, 4) : (r == 7) ? 0 : (r == 8) ? TMO : TMO - 1;
      do_op(addr, $urandom(), 5'($urandom()), 1'($urandom_range(0, 1)),
            kind == 1, kind == 2, lat, $urandom());
    end

    // Reset in the middle of an access: discard it, no writeback.
    ex_valid      = 1'b1;
    ex_alu_result = 32'h0000_0800;
    ex_rt_value   = 32'hA5A5_A5A5;
    ex_dest_reg   = 5'd12;
    ex_reg_write  = 1'b1;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_access_req", dmem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("reset_req_drop", dmem_req, 0);
    check("reset_ex_ready", ex_ready, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check_reset_values();
    do_op(32'h0000_0044, $urandom(), 5'd17, 1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the execute stage. It accepts the ALU result, store data and destination register from execute, performs loads and stores against a data memory over a request/acknowledge handshake, and presents a registered writeback bundle to the writeback stage. While a memory access is outstanding it back-pressures execute via `ex_ready`, and it flags misaligned addresses and memory timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of cycles in ACCESS without `dmem_ack` before the access is aborted; legal range 2..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `ex_valid` in 1: execute presents a valid instruction.
- `ex_ready` out 1: stage can accept; a transfer occurs when `ex_valid & ex_ready`.
- `ex_alu_result` in 32: ALU result; also the memory byte address for loads and stores.
- `ex_rt_value` in 32: store data.
- `ex_dest_reg` in 5: destination register.
- `ex_reg_write` in 1: instruction writes a register.
- `ex_mem_read` in 1: load word.
- `ex_mem_write` in 1: store word. Never asserted together with `ex_mem_read`.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out 32: word-aligned byte address.
- `dmem_wdata` out 32: store data.
- `dmem_ack` in 1: request completed this cycle; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: load data.
- `wb_valid` out 1: one-cycle pulse; the writeback bundle is valid.
- `wb_reg_write` out 1: writeback enable.
- `wb_dest_reg` out 5: writeback register.
- `wb_data` out 32: writeback value.
- `mem_error` out 1: one-cycle pulse on a misaligned access or a timeout.

## Operation
- FSM states are IDLE and ACCESS. `ex_ready = (state == IDLE)`, combinational from state only.
- **IDLE, non-memory transfer:** on the next edge `wb_valid` = 1, `wb_data = ex_alu_result`, `wb_reg_write = ex_reg_write`, `wb_dest_reg = ex_dest_reg`. State stays IDLE.
- **IDLE, memory transfer with `ex_alu_result[1:0] == 0`:**
  - Latch address, data, dest, `we`, and `reg_write` (load ⇒ `ex_reg_write`; store ⇒ 0).
  - Go to ACCESS and clear the timeout counter.
- **IDLE, memory transfer with `ex_alu_result[1:0] != 0`:**
  - No request is issued.
  - Next edge: `mem_error` = 1, `wb_valid` = 1, `wb_reg_write` = 0. Stay IDLE.
- **ACCESS:**
  - `dmem_req` = 1; `dmem_addr`, `dmem_we` and `dmem_wdata` are held stable until the request ends.
  - Counter increments every cycle.
- **ACCESS, `dmem_ack` = 1:**
  - Next edge: `wb_valid` = 1, `wb_data = dmem_rdata` for loads and the address for stores.
  - Dest and `reg_write` come from the latched values. Go to IDLE.
- **ACCESS, counter reaches `TIMEOUT_CYCLES - 1` without ack:**
  - Next edge: `dmem_req` drops, `mem_error` = 1, `wb_valid` = 1, `wb_reg_write` = 0. Go to IDLE.
  - If ack and timeout occur in the same cycle, ack wins.
- `wb_valid` and `mem_error` are high for exactly one cycle per event.
- `wb_data`, `wb_dest_reg` and `wb_reg_write` hold their values between pulses. The writeback stage qualifies them with `wb_valid`.
- `dmem_ack` outside ACCESS is ignored.

## Timing
- **Reset values:** state IDLE; `ex_ready` 1; `dmem_req` 0; `dmem_we` 0; `dmem_addr` 0; `dmem_wdata` 0; `wb_valid` 0; `wb_reg_write` 0; `wb_dest_reg` 0; `wb_data` 0; `mem_error` 0; counter 0.
- **Reset mid-access:** `dmem_req` drops asynchronously and the in-flight access is discarded with no `wb_valid`.
- **Non-memory op:** transfer at edge T, `wb_valid` during cycle T+1. Back-to-back transfers give one `wb_valid` per cycle.
- **Memory op:**
  - Transfer at edge T; `dmem_req` high from T+1.
  - Ack sampled at edge T+k (k ≥ 1): `wb_valid` during T+k+1.
  - `ex_ready` is 0 during cycles T+1..T+k and 1 again in T+k+1. A new instruction can be accepted at that edge.
- **Minimum load-to-load throughput:** one load every 2 cycles.
- **Upstream rule:** execute holds its outputs stable while `ex_valid & !ex_ready`.

## Structure
- Shared pipeline package holds:
  - the FSM state encoding (`MS_IDLE`, `MS_ACCESS`);
  - the register-index width (5) and data width (32) constants;
  - the writeback bundle typedef (valid, reg_write, dest, data), shared with the writeback stage.
- One natural sub-module: `mem_timeout_ctr`, a clearable up-counter with a terminal-count output, sized from `TIMEOUT_CYCLES`.

## Test plan
- **ALU op, then ALU op:** `ex_alu_result` = 0x0000_0010 then 0x0000_0020, dest 3 then 4, reg_write 1, both back-to-back → `wb_valid` in two consecutive cycles with data 0x10/r3 then 0x20/r4; `dmem_req` stays 0.
- **Load at 0x0000_0100, ack after 3 cycles with `dmem_rdata` = 0xDEAD_BEEF, dest 8:**
  - `dmem_req` is high for 3 cycles with address 0x100 and `we` = 0.
  - `ex_ready` is low for those 3 cycles.
  - Then `wb_valid`, `wb_data` = 0xDEADBEEF, `wb_dest_reg` = 8, `wb_reg_write` = 1.
- **Store of 0x1234_5678 to 0x0000_0200, ack on first cycle:** `dmem_we` = 1, `dmem_wdata` = 0x12345678; `wb_valid` with `wb_reg_write` = 0 two cycles after the transfer.
- **Load at 0x0000_0102:** no `dmem_req`; next cycle `mem_error` = 1 and `wb_valid` = 1 with `wb_reg_write` = 0.
- **Load, ack never given, `TIMEOUT_CYCLES` = 16:**
  - `dmem_req` high for exactly 16 cycles.
  - Then `mem_error` and `wb_valid` pulse, `wb_reg_write` = 0, and `ex_ready` returns to 1.
  - Also cover ack arriving on the 16th cycle → normal completion and no `mem_error`.
- **`reset` pulled low during ACCESS:** `dmem_req` falls immediately and no `wb_valid` follows. After release, all outputs are at their reset values and a new ALU op completes normally.
